// File: rtl/pred_lt_3.sv
// pred_lt_3: 1/3-resolution fractional-pitch long-term predictor.
// For each output sample j, 20 taps of the inter_3l filter are accumulated
// through an external saturating L_mac. The sample is then rounded and written
// back to exc[j]. Later taps may read samples written earlier in the same call.
// Optional build macro: PRED_LT3_ROUND_SAT_EN saturates the rounding add
// (default: the rounding add wraps in 32 bits).
module pred_lt_3 #(
    parameter logic [11:0] INTER_3L_BASE = 12'd0,
    parameter int          L_INTER10     = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        done,
    input  logic [11:0] exc,
    input  logic [15:0] T0,
    input  logic [15:0] frac,
    input  logic [15:0] L_subfr,
    output logic [11:0] readAddr,
    input  logic [31:0] readIn,
    output logic [11:0] writeAddr,
    output logic [31:0] writeOut,
    output logic        writeEn,
    output logic [11:0] constantMemAddr,
    input  logic [31:0] constantMemIn,
    output logic [15:0] L_mac_a,
    output logic [15:0] L_mac_b,
    output logic [31:0] L_mac_c,
    input  logic [31:0] L_mac_in
);

    localparam int            NTERMS = 2 * L_INTER10;
    localparam int            KW     = $clog2(NTERMS);
    localparam logic [KW-1:0] K_LAST = KW'(NTERMS - 1);

    typedef enum logic [2:0] {
        S_INIT, S_SETUP, S_ADDR, S_MAC, S_WRITE, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [11:0]   exc_q, exc_d;
    logic [11:0]   t0_q, t0_d;
    logic [11:0]   x0_q, x0_d;
    logic [15:0]   frac_q, frac_d;
    logic [15:0]   lsub_q, lsub_d;
    logic [15:0]   j_q, j_d;
    logic [1:0]    f_q, f_d;
    logic [KW-1:0] k_q, k_d;
    logic [31:0]   s_q, s_d;

    logic [11:0]   read_addr_q, read_addr_d;
    logic [11:0]   coef_addr_q, coef_addr_d;
    logic [11:0]   write_addr_q, write_addr_d;
    logic [31:0]   write_out_q, write_out_d;
    logic          write_en_q, write_en_d;
    logic          done_q, done_d;

    logic [11:0]   tap_i, tap_3i;
    logic [31:0]   rsum;
    logic          unused_bits;

    // Sequencer: next state, counters, latched call arguments and accumulator
    always_comb begin
        state_d = state_q;
        exc_d   = exc_q;
        t0_d    = t0_q;
        frac_d  = frac_q;
        lsub_d  = lsub_q;
        x0_d    = x0_q;
        f_d     = f_q;
        k_d     = k_q;
        j_d     = j_q;
        s_d     = s_q;
        unique case (state_q)
            S_INIT: begin
                if (start) begin
                    state_d = S_SETUP;
                    exc_d   = exc;
                    t0_d    = T0[11:0];
                    frac_d  = frac;
                    lsub_d  = L_subfr;
                end
            end
            S_SETUP: begin
                // f = -frac; a negative f is folded to f+3 with x0 moved back one
                x0_d = exc_q - t0_q;
                f_d  = 2'd0;
                if ($signed(frac_q) > 16'sd0) begin
                    f_d  = 2'd2;
                    x0_d = exc_q - t0_q - 12'd1;
                end else if ($signed(frac_q) < 16'sd0) begin
                    f_d = 2'd1;
                end
                j_d     = '0;
                k_d     = '0;
                s_d     = '0;
                state_d = S_ADDR;
            end
            S_ADDR: begin
                state_d = S_MAC;
            end
            S_MAC: begin
                s_d = L_mac_in;
                if (k_q == K_LAST) begin
                    state_d = S_WRITE;
                end else begin
                    k_d     = k_q + KW'(1);
                    state_d = S_ADDR;
                end
            end
            S_WRITE: begin
                if (j_q + 16'd1 >= lsub_q) begin
                    state_d = S_DONE;
                end else begin
                    j_d     = j_q + 16'd1;
                    k_d     = '0;
                    s_d     = '0;
                    state_d = S_ADDR;
                end
            end
            S_DONE: begin
                state_d = S_INIT;
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    // Output values for the coming cycle, derived from the next state so they register cleanly.
    // Even terms use the x1 side (mem[x0+j-i], C[f+3i]); odd terms use the x2 side
    // (mem[x0+j+1+i], C[3-f+3i]).
    always_comb begin
        tap_i       = 12'(k_d[KW-1:1]);
        tap_3i      = tap_i * 12'd3;
        read_addr_d = '0;
        coef_addr_d = '0;
        if (state_d == S_ADDR) begin
            if (!k_d[0]) begin
                read_addr_d = x0_d + j_d[11:0] - tap_i;
                coef_addr_d = INTER_3L_BASE + 12'(f_d) + tap_3i;
            end else begin
                read_addr_d = x0_d + j_d[11:0] + 12'd1 + tap_i;
                coef_addr_d = INTER_3L_BASE + 12'd3 - 12'(f_d) + tap_3i;
            end
        end
        rsum = s_d + 32'h0000_8000;
`ifdef PRED_LT3_ROUND_SAT_EN
        if (!s_d[31] && rsum[31]) begin
            rsum = 32'h7FFF_FFFF;
        end
`endif
        write_en_d   = (state_d == S_WRITE);
        write_addr_d = write_en_d ? (exc_q + j_d[11:0]) : '0;
        write_out_d  = write_en_d ? {{16{rsum[31]}}, rsum[31:16]} : '0;
        done_d       = (state_d == S_DONE);
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_INIT;
            exc_q        <= '0;
            t0_q         <= '0;
            frac_q       <= '0;
            lsub_q       <= '0;
            x0_q         <= '0;
            f_q          <= '0;
            k_q          <= '0;
            j_q          <= '0;
            s_q          <= '0;
            read_addr_q  <= '0;
            coef_addr_q  <= '0;
            write_addr_q <= '0;
            write_out_q  <= '0;
            write_en_q   <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            exc_q        <= exc_d;
            t0_q         <= t0_d;
            frac_q       <= frac_d;
            lsub_q       <= lsub_d;
            x0_q         <= x0_d;
            f_q          <= f_d;
            k_q          <= k_d;
            j_q          <= j_d;
            s_q          <= s_d;
            read_addr_q  <= read_addr_d;
            coef_addr_q  <= coef_addr_d;
            write_addr_q <= write_addr_d;
            write_out_q  <= write_out_d;
            write_en_q   <= write_en_d;
            done_q       <= done_d;
        end
    end

    // MAC operands are only presented while the sample/coefficient data is valid
    always_comb begin
        L_mac_a = '0;
        L_mac_b = '0;
        L_mac_c = '0;
        if (state_q == S_MAC) begin
            L_mac_a = readIn[15:0];
            L_mac_b = constantMemIn[15:0];
            L_mac_c = s_q;
        end
    end

    assign readAddr        = read_addr_q;
    assign constantMemAddr = coef_addr_q;
    assign writeAddr       = write_addr_q;
    assign writeOut        = write_out_q;
    assign writeEn         = write_en_q;
    assign done            = done_q;

    assign unused_bits = ^{readIn[31:16], constantMemIn[31:16], T0[15:12], rsum[15:0]};

endmodule

// File: doc/pred_lt_3.md
PRED_LT_3 -- requirements
Module: Pred_lt_3

Interface
REQ-001 SHALL have parameter INTER_3L_BASE, default 12'd0, constant-memory address of inter_3l[0] (31 Q15 taps).
REQ-002 SHALL have parameter L_INTER10, default 10, half-length of the interpolation filter in taps.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on the rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1, begin request, sampled in INIT.
REQ-006 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-007 SHALL have port exc, input, 12, scratch-memory address of exc[0].
REQ-008 SHALL have port T0, input, 16, integer pitch lag, 20..143.
REQ-009 SHALL have port frac, input, 16, signed fraction, -1, 0 or 1.
REQ-010 SHALL have port L_subfr, input, 16, number of output samples, 1..40.
REQ-011 SHALL have port readAddr, output, 12, scratch read address; readIn is valid in the following cycle.
REQ-012 SHALL have port readIn, input, 32, scratch read data; the sample is in bits [15:0].
REQ-013 SHALL have port writeAddr, output, 12, scratch write address.
REQ-014 SHALL have port writeOut, output, 32, write data.
REQ-015 SHALL have port writeEn, output, 1, write strobe.
REQ-016 SHALL have port constantMemAddr, output, 12, coefficient address; constantMemIn is valid in the following cycle.
REQ-017 SHALL have port constantMemIn, input, 32, coefficient data in bits [15:0].
REQ-018 SHALL have ports L_mac_a, L_mac_b (output, 16) and L_mac_c (output, 32), feeding the shared saturating L_mac.
REQ-019 SHALL have port L_mac_in, input, 32, the shared L_mac result.

Function
REQ-020 SHALL latch exc, T0, frac and L_subfr when start is sampled high in INIT, and ignore start in every other state.
REQ-021 SHALL compute the setup in SETUP as follows:
- x0 = exc - T0 and f = -frac;
- if f < 0, then f = f + 3 and x0 = x0 - 1.
REQ-022 SHALL perform, for each j in 0..L_subfr-1 and each i in 0..9, two operations:
- s = L_mac(s, mem[x0+j-i], C[f+3i]);
- s = L_mac(s, mem[x0+j+1+i], C[3-f+3i]);
- s is cleared to 0 at the start of each j.
REQ-023 SHALL spend exactly 2 cycles per MAC term, address cycle then MAC cycle, so each sample takes 40 MAC cycles plus 1 write cycle (41 cycles).
REQ-024 SHALL, in the write cycle, assert writeEn with writeAddr = exc + j and writeOut = sign-extended round(s), where round(s) = (s + 0x8000) >> 16.
REQ-025 SHALL use the states INIT -> SETUP -> {ADDR <-> MAC} x 20 -> WRITE, then either loop back to ADDR or go to DONE, then return to INIT.
REQ-026 SHALL assert done only in DONE, exactly 2 + 41*L_subfr cycles after the start cycle (the start cycle counts as cycle 0).
REQ-027 SHALL wrap all address arithmetic modulo 4096.
REQ-028 SHALL read back samples written earlier in the same call (x0+j+1+i >= exc when T0 is small), matching the recursive C reference.
REQ-029 SHALL drive writeEn, the L_mac operands and the addresses to 0 in every cycle where they are not in use.

Reset
REQ-030 SHALL, on reset, including mid-operation, go to INIT, drive done=0 and writeEn=0, clear all counters and the accumulator, and issue no further writes.
REQ-031 SHALL drive every output to 0 in the cycle after reset is released.

Configuration
REQ-032 SHALL, when PRED_LT3_ROUND_SAT_EN is defined, saturate s + 0x8000 at 0x7FFFFFFF before taking the upper half.
REQ-033 SHALL, when PRED_LT3_ROUND_SAT_EN is undefined, let s + 0x8000 wrap in 32 bits.

Verification
REQ-034 Zero history: all exc[-143..-1]=0, T0=40, frac=0, L_subfr=40 -> 40 writes of 0; done at cycle 1642.
REQ-035 Integer lag: C[0]=16384 and all other taps 0, exc[-40]=1000, T0=40, frac=0, L_subfr=1 -> writeOut=500 at exc+0; done at cycle 43.
REQ-036 Fraction adjust: C[2]=16384 and all other taps 0, exc[-41]=-2000, T0=40, frac=1, L_subfr=1 -> x0=exc-41, f=2; writeOut=-1000.
REQ-037 Saturation: C[0]=C[3]=32767, exc[-40]=exc[-39]=32767, T0=40, frac=0, L_subfr=1 -> s=0x7FFFFFFF:
- with PRED_LT3_ROUND_SAT_EN, writeOut=32767;
- without it, writeOut=0xFFFF8000.
REQ-038 Recursion and abort:
- T0=20, L_subfr=40: at j=30 the x2 term with i=0 reads exc+11 and sees the value written at j=11.
- Reset asserted in cycle 100 -> no further writeEn, done=0, state INIT.
